// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and helpers for the RNG arbiter slice.
package rng_pkg;

    // xorshift32 shift amounts
    localparam int unsigned SHIFT_A = 13;
    localparam int unsigned SHIFT_B = 17;
    localparam int unsigned SHIFT_C = 5;

    // Substitute for an all-zero state, which would never leave zero
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_MAX_TRIES = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        ACK
    } arb_state_t;

    // Smallest 2^k-1 that covers lim (0 maps to 0)
    function automatic logic [7:0] range_mask(input logic [7:0] lim);
        logic [7:0] m;
        m = lim | (lim >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

    // Replicate the seed byte across the state, avoiding the lock-up state
    function automatic logic [31:0] seed_expand(input logic [7:0] s);
        return (s == 8'h00) ? ZERO_SEED_SUB : {4{s}};
    endfunction

endpackage

// File: rtl/rng_engine.sv
// 32-bit xorshift engine (13/17/5); advances on step, reseeds on load.
module rng_engine
    import rng_pkg::*;
#(
    parameter logic [7:0] SEED_DEFAULT = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       step,
    input  logic       load,
    input  logic [7:0] load_seed,
    output logic [7:0] next_low
);

    logic [31:0] s;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;

    // Combinational engine step on the current state
    always_comb begin
        s1       = s ^ (s << SHIFT_A);
        s2       = s1 ^ (s1 >> SHIFT_B);
        s3       = s2 ^ (s2 << SHIFT_C);
        next_low = s3[7:0];
    end

    // State register: load has priority over step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s <= seed_expand(SEED_DEFAULT);
        end else if (load) begin
            s <= seed_expand(load_seed);
        end else if (step) begin
            s <= s3;
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one xorshift engine among NUM_REQ requesters,
// with mask-and-reject range reduction and sequenced reseeding.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned MAX_TRIES    = DEF_MAX_TRIES,
    parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 seed_load,
    input  logic [7:0]           seed,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] limit,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           value,
    output logic                 busy
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);

    arb_state_t    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [PW-1:0] pick;
    logic          found;
    int unsigned   rr_idx;
    logic [7:0]    lim_q, lim_d;
    logic [7:0]    value_q, value_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          pend_q, pend_d;
    logic [7:0]    seed_q;
    logic          pend_eff;
    logic [7:0]    seed_eff;
    logic          eng_step;
    logic          eng_load;
    logic [7:0]    rnd;
    logic [7:0]    mask;
    logic [7:0]    cand;

    rng_engine #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_engine (
        .clk      (clk),
        .resetn   (resetn),
        .step     (eng_step),
        .load     (eng_load),
        .load_seed(seed_eff),
        .next_low (rnd)
    );

    // A seed_load arriving in IDLE is applied that same cycle, so it is folded into the pending view
    always_comb begin
        pend_eff = pend_q | seed_load;
        seed_eff = seed_load ? seed : seed_q;
        pend_d   = pend_q;
        if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else if (seed_load) begin
            pend_d = 1'b1;
        end
    end

    // First requester at or after the pointer, wrapping around
    always_comb begin
        pick   = ptr_q;
        found  = 1'b0;
        rr_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = 32'(ptr_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!found && req[rr_idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = rr_idx[PW-1:0];
            end
        end
    end

    // Candidate value from the engine output for the granted limit
    always_comb begin
        mask = range_mask(lim_q);
        cand = rnd & mask;
    end

    // FSM next-state, grant and draw decisions
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        lim_d    = lim_q;
        tries_d  = tries_q;
        value_d  = value_q;
        eng_step = 1'b0;
        eng_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_eff) begin
                    eng_load = 1'b1;
                end else if (found) begin
                    gnt_d   = pick;
                    lim_d   = limit[32'(pick)*8 +: 8];
                    tries_d = TW'(1);
                    ptr_d   = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + PW'(1);
                    state_d = DRAW;
                end
            end
            DRAW: begin
                eng_step = 1'b1;
                if (cand <= lim_q) begin
                    value_d = cand;
                    state_d = ACK;
                end else if (tries_q == TW'(MAX_TRIES)) begin
                    // mask < 2*(limit+1), so this always lands in [0, limit]
                    value_d = cand - lim_q - 8'd1;
                    state_d = ACK;
                end else begin
                    tries_d = tries_q + TW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            lim_q   <= '0;
            tries_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            lim_q   <= lim_d;
            tries_q <= tries_d;
            value_q <= value_d;
        end
    end

    // Pending reseed flag and latched seed byte
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 1'b0;
            seed_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (seed_load) begin
                seed_q <= seed;
            end
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        ack = '0;
        if (state_q == ACK) begin
            ack[gnt_q] = 1'b1;
        end
        busy  = (state_q != IDLE);
        value = value_q;
    end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one 32-bit xorshift engine (shifts 13, 17, 5) between `NUM_REQ` game-logic requesters, e.g. letter spawner, colour picker and position picker. Arbitration is round-robin. Each requester asks for a uniform value in `[0, limit]` and receives it over a req/ack handshake. Range reduction uses mask-and-reject with a bounded fallback. The block also sequences engine reseeding and guards against the all-zero lock-up state.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_TRIES`, 8: draws per request before the fallback applies, ≥1.
- `SEED_DEFAULT`, 8'hA5: seed byte applied at reset.
- `clk`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `seed_load`  in  1  one-cycle pulse requesting a reseed.
- `seed`  in  8  seed byte, sampled with `seed_load`.
- `req`  in  NUM_REQ  level request per requester.
- `limit`  in  8*NUM_REQ  inclusive upper bound per requester; byte i belongs to requester i.
- `ack`  out  NUM_REQ  one-cycle completion pulse, one-hot or zero.
- `value`  out  8  result; valid while ack is high and held until the next ack.
- `busy`  out  1  high while a draw is in progress or being acknowledged.

## Operation
- Engine step, combinational on state s:
  - s1 = s ^ (s<<13)
  - s2 = s1 ^ (s1>>17)
  - s3 = s2 ^ (s2<<5)
  - All terms are 32-bit and truncated. The engine advances only in DRAW, never while idle.
- Seed mapping: state = {4{seed}}. Seed 8'h00 maps to 32'h0000_0001 instead, because an all-zero state never leaves zero.
- FSM states and transitions:
  - IDLE:
    - Pending seed → load the engine and stay in IDLE.
    - Else any `req` bit high → grant, latch `limit` of the winner, go to DRAW.
    - Else stay in IDLE.
  - DRAW: step the engine. cand = s3[7:0] & mask, where mask = smallest 2^k−1 ≥ limit (limit 0 → mask 0).
    - cand ≤ limit → value := cand, go to ACK.
    - Else, if this was draw number MAX_TRIES → value := cand − (limit+1), go to ACK. The result is always ≤ limit because mask < 2·(limit+1).
    - Else stay in DRAW.
  - ACK: `ack[winner]` is high for exactly this cycle. `req` is ignored. Go to IDLE.
- Round-robin:
  - Pointer holds the index after the last winner; reset value is 0.
  - The winner is the first set `req` bit at or after the pointer, wrapping around.
  - On grant, pointer := winner+1 mod NUM_REQ.
- Handshake rules:
  - A requester holds `req` until it sees `ack`, then drops `req` the next cycle.
  - Dropping `req` mid-draw does not abort the draw. The ack is still delivered.
  - `limit` is sampled only at grant.
- Seeding:
  - `seed_load` sets a pending flag and latches `seed`. This works in any state.
  - A second pulse before the seed is applied overwrites the latched byte.
  - The seed is applied in the next IDLE cycle and has priority over `req`. The draw in progress completes on the old sequence.
- Reset values:
  - state = {4{SEED_DEFAULT}}
  - FSM = IDLE
  - `ack` = 0, `value` = 0, `busy` = 0
  - pointer = 0, pending flag = 0

## Timing
- `req` high in IDLE at cycle 0 → DRAW in cycle 1 → `ack` and `value` in cycle 2 when the first draw is accepted.
- Each rejection adds one cycle. Worst case: ack in cycle MAX_TRIES+1.
- Back-to-back grants are spaced by at least one IDLE cycle. Minimum period per grant is 3 cycles.
- `busy` is high in DRAW and ACK, low in IDLE.
- A pending seed delays the next grant by exactly one cycle.
- `seed_load` in the same cycle as a `req` rising in IDLE: the seed wins, and the request is granted the following cycle.
- `resetn` low asynchronously clears all state mid-draw. No `ack` is issued for the aborted request.

## Structure
- Package `rng_pkg` holds:
  - shift constants 13/17/5
  - zero-seed substitute 32'h0000_0001
  - FSM state enum {IDLE, DRAW, ACK}
  - default `NUM_REQ` and `MAX_TRIES`
- Sub-module `rng_engine`:
  - owns the 32-bit state register
  - inputs: `step`, `load`, `load_seed[7:0]`
  - outputs: `next_low[7:0]`, i.e. s3[7:0]
  - has the same async reset as the top
- The arbiter FSM, mask generation and round-robin logic live in `rng_arbiter`.

## Test plan
- Reseed with seed=0x00, then `req[0]` with limit=0xFF → state becomes 0x1. Ack in cycle 2 with value=0x21 (next state 0x00042021).
- Reseed with seed=0x00, then `req[1]` with limit=0x1F → mask 0x1F, cand 0x01, value=0x01 in cycle 2.
- limit=0x00 → value=0 and ack on the first draw, every time. Over 1000 draws with limit=0x64, every value ≤ 0x64 and every ack arrives within MAX_TRIES+1 cycles.
- All four `req` held high continuously, each dropped for one cycle after its ack → grant order is 0,1,2,3,0… with no starvation.
- `seed_load` pulsed during DRAW → the current ack keeps its old-sequence value. The next IDLE cycle loads the new seed, and the next grant is delayed by one cycle.
- `resetn` asserted mid-DRAW → no ack. After release: `value`=0, pointer=0, state={4{0xA5}}, and the first draw matches the golden model.
